// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between the execute ALU and writeback.
// Latency: non-memory ops 1 cycle; loads/stores hold one request at a time until grant/response.
// Backpressure: in_ready only in IDLE; stall = !in_ready while an access is in flight.
// Ports: clk/rst_n (async active-low); in_* execute-stage instruction + flush;
//        mem_* request/grant/response data-memory port; wb_* registered writeback record.
// Optional: define MEM_ALIGN_CHECK_EN to turn misaligned loads/stores into wb_err
//           instead of silently word-aligning the address.
module mem_stage #(
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int TID_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_alu_out,
  input  logic [XLEN-1:0]  in_st_data,
  input  logic             in_mem_rd,
  input  logic             in_mem_wr,
  input  logic             in_reg_wr,
  input  logic [REG_W-1:0] in_rd,
  input  logic [TID_W-1:0] in_tid,
  input  logic             flush,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             wb_valid,
  output logic             wb_reg_wr,
  output logic [REG_W-1:0] wb_rd,
  output logic [TID_W-1:0] wb_tid,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  // Counter wide enough to hold TIMEOUT; it saturates at all-ones.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_st;
  logic             r_reg_wr;
  logic [REG_W-1:0] r_rd;
  logic [TID_W-1:0] r_tid;

  logic w_accept, w_mem_op, w_tmo;
  logic w_issue, w_req_clr, w_cnt_clr, w_cnt_inc;
  logic w_wb_alu, w_wb_st, w_wb_ld, w_wb_tmo;
`ifdef MEM_ALIGN_CHECK_EN
  logic w_wb_mis;
`endif

  assign in_ready = (r_state == S_IDLE);
  assign stall    = !in_ready;
  assign w_accept = in_valid & in_ready & !flush;
  assign w_mem_op = in_mem_rd | in_mem_wr;
  // Last allowed WAIT/DRAIN cycle: a response here still wins over the timeout.
  assign w_tmo    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_req_clr = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_wb_alu  = 1'b0;
    w_wb_st   = 1'b0;
    w_wb_ld   = 1'b0;
    w_wb_tmo  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    w_wb_mis  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_mem_op) begin
            w_wb_alu = 1'b1;
          end else begin
`ifdef MEM_ALIGN_CHECK_EN
            if (in_alu_out[1:0] != 2'b00) begin
              w_wb_mis = 1'b1;
            end else begin
              w_issue = 1'b1;
              w_next  = S_REQ;
            end
`else
            w_issue = 1'b1;
            w_next  = S_REQ;
`endif
          end
        end
      end
      S_REQ: begin
        // A grant in the same cycle as flush still counts: the access is
        // already committed on the bus, so a load must drain its response.
        if (mem_gnt) begin
          w_req_clr = 1'b1;
          if (r_is_st) begin
            w_next  = S_IDLE;
            w_wb_st = !flush;
          end else begin
            w_cnt_clr = 1'b1;
            w_next    = flush ? S_DRAIN : S_WAIT;
          end
        end else if (flush) begin
          w_req_clr = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          // Response coinciding with flush is consumed and dropped.
          w_next  = S_IDLE;
          w_wb_ld = !flush;
        end else if (flush) begin
          w_cnt_inc = 1'b1;
          w_next    = S_DRAIN;
        end else if (w_tmo) begin
          w_wb_tmo = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid || w_tmo) begin
          w_next = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_is_st   <= 1'b0;
      r_reg_wr  <= 1'b0;
      r_rd      <= '0;
      r_tid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_reg_wr <= 1'b0;
      wb_rd     <= '0;
      wb_tid    <= '0;
      wb_data   <= '0;
      wb_err    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_err   <= 1'b0;

      if (w_issue) begin
        mem_req   <= 1'b1;
        mem_we    <= in_mem_wr;
        mem_addr  <= {in_alu_out[XLEN-1:2], 2'b00};
        mem_wdata <= in_st_data;
        r_is_st   <= in_mem_wr;
        r_reg_wr  <= in_reg_wr;
        r_rd      <= in_rd;
        r_tid     <= in_tid;
      end
      if (w_req_clr) begin
        mem_req <= 1'b0;
      end

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_wb_alu) begin
        wb_valid  <= 1'b1;
        wb_data   <= in_alu_out;
        wb_reg_wr <= in_reg_wr;
        wb_rd     <= in_rd;
        wb_tid    <= in_tid;
      end
`ifdef MEM_ALIGN_CHECK_EN
      if (w_wb_mis) begin
        wb_valid  <= 1'b1;
        wb_err    <= 1'b1;
        wb_reg_wr <= 1'b0;
        wb_rd     <= in_rd;
        wb_tid    <= in_tid;
      end
`endif
      // Completions of a latched access; only a good load writes a register.
      if (w_wb_st | w_wb_ld | w_wb_tmo) begin
        wb_valid  <= 1'b1;
        wb_err    <= w_wb_tmo;
        wb_reg_wr <= w_wb_ld & r_reg_wr;
        wb_rd     <= r_rd;
        wb_tid    <= r_tid;
      end
      if (w_wb_ld) begin
        wb_data <= mem_rdata;
      end
    end
  end

endmodule
